// File: rtl/game_link_pkg.sv
// Shared definitions for the ball hand-off link between the two game boards.
// Imported by the local packetizer and by the peer's receive decoder, so the
// frame layout is defined in exactly one place.
//   FRAME_LEN / IDX_*    : byte positions within the 6-byte write frame
//   ball_frame_t         : ball state latched at trigger time
//   tx_state_t           : packetizer FSM states
//   SLOW_THRESH_DEFAULT  : default speed-class threshold
package game_link_pkg;

    localparam int FRAME_LEN = 6;

    localparam logic [2:0] IDX_REG_PTR = 3'd0;
    localparam logic [2:0] IDX_Y_HI    = 3'd1;
    localparam logic [2:0] IDX_Y_LO    = 3'd2;
    localparam logic [2:0] IDX_VY      = 3'd3;
    localparam logic [2:0] IDX_GRAV    = 3'd4;
    localparam logic [2:0] IDX_SLOW    = 3'd5;
    localparam logic [2:0] IDX_LAST    = 3'(FRAME_LEN - 1);

    localparam logic [19:0] SLOW_THRESH_DEFAULT = 20'd200000;

    typedef struct packed {
        logic [9:0] y;
        logic [7:0] vy;
        logic [1:0] g;
        logic       slow;
    } ball_frame_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_SEND,
        ST_WAIT_DONE,
        ST_RETRY,
        ST_DONE
    } tx_state_t;

endpackage

// File: rtl/ball_frame_encoder.sv
// Combinational frame encoder: maps the latched ball state and a byte index
// to the byte the peer stores in its register file.
//   frame     : latched ball state
//   byte_idx  : position within the frame (0 = register pointer)
//   byte_data : encoded byte; indices past the frame read as 0
module ball_frame_encoder
    import game_link_pkg::*;
#(
    parameter logic [7:0] REG_BASE = 8'h00
) (
    input  ball_frame_t frame,
    input  logic [2:0]  byte_idx,
    output logic [7:0]  byte_data
);

    always_comb begin
        byte_data = 8'h00;
        case (byte_idx)
            IDX_REG_PTR: byte_data = REG_BASE;
            // y high bits sit in [7:6] so the peer rebuilds y as {reg0[7:6], reg1}
            IDX_Y_HI:    byte_data = {frame.y[9:8], 6'b000000};
            IDX_Y_LO:    byte_data = frame.y[7:0];
            IDX_VY:      byte_data = frame.vy;
            IDX_GRAV:    byte_data = {6'b000000, frame.g};
            IDX_SLOW:    byte_data = {7'b0000000, frame.slow};
            default:     byte_data = 8'h00;
        endcase
    end

endmodule

// File: rtl/ball_tx_packetizer.sv
// Captures the ball state when the local controller hands the ball over and
// streams it to the I2C master core as one write transaction, retrying on
// NACK or watchdog timeout, then pulses is_i2c_master_done to the controller.
//   clk_25MHZ, reset            : clock, async active-high reset
//   ball_send_trigger           : send request level (rising edge starts)
//   ball_y/ball_vy/gravity_counter/ball_speed : ball state to capture
//   i2c_start/addr/wdata/wvalid/wlast, i2c_wready : byte stream to master
//   i2c_txn_done, i2c_nack      : transaction completion from master
//   is_i2c_master_done          : one-cycle completion pulse to controller
//   tx_busy, tx_error, retry_cnt: status / debug
//
// state      | meaning
// -----------+----------------------------------------------------------
// IDLE       | waiting for trigger rising edge; latches ball state
// START      | one-cycle i2c_start pulse, rewinds byte index and watchdog
// SEND       | presenting frame bytes to the master
// WAIT_DONE  | all bytes accepted, waiting for the stop condition
// RETRY      | attempt failed; re-send or give up with tx_error
// DONE       | one-cycle completion pulse to the controller
module ball_tx_packetizer
    import game_link_pkg::*;
#(
    parameter logic [6:0]  SLAVE_ADDR  = 7'h17,
    parameter logic [7:0]  REG_BASE    = 8'h00,
    parameter logic [1:0]  MAX_RETRY   = 2'd3,
    parameter logic [19:0] TIMEOUT_CYC = 20'd250000,
    parameter logic [19:0] SLOW_THRESH = SLOW_THRESH_DEFAULT
) (
    input  logic        clk_25MHZ,
    input  logic        reset,
    input  logic        ball_send_trigger,
    input  logic [9:0]  ball_y,
    input  logic [7:0]  ball_vy,
    input  logic [1:0]  gravity_counter,
    input  logic [19:0] ball_speed,
    output logic        i2c_start,
    output logic [6:0]  i2c_addr,
    output logic [7:0]  i2c_wdata,
    output logic        i2c_wvalid,
    output logic        i2c_wlast,
    input  logic        i2c_wready,
    input  logic        i2c_txn_done,
    input  logic        i2c_nack,
    output logic        is_i2c_master_done,
    output logic        tx_busy,
    output logic        tx_error,
    output logic [1:0]  retry_cnt
);

    tx_state_t   state_q;
    tx_state_t   state_nxt;
    logic        trigger_d;
    logic        trig_rise;
    ball_frame_t frame_q;
    logic [2:0]  byte_idx_q;
    logic [19:0] timer_q;
    logic        in_window;
    logic        timeout_hit;
    logic [7:0]  enc_byte;

    logic capture;
    logic load_attempt;
    logic idx_inc;
    logic retry_inc;
    logic set_err;

    assign trig_rise   = ball_send_trigger & ~trigger_d;
    assign in_window   = (state_q == ST_SEND) || (state_q == ST_WAIT_DONE);
    // Watchdog is a down-counter loaded at START; terminal count means the
    // attempt has used its full TIMEOUT_CYC cycles in SEND/WAIT_DONE.
    assign timeout_hit = in_window && (timer_q == 20'd0);

    ball_frame_encoder #(
        .REG_BASE (REG_BASE)
    ) u_encoder (
        .frame     (frame_q),
        .byte_idx  (byte_idx_q),
        .byte_data (enc_byte)
    );

    assign i2c_addr  = SLAVE_ADDR;
    assign i2c_wdata = i2c_wvalid ? enc_byte : 8'h00;
    assign i2c_wlast = i2c_wvalid && (byte_idx_q == IDX_LAST);
    assign tx_busy   = (state_q != ST_IDLE);

    always_ff @(posedge clk_25MHZ or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_comb begin
        state_nxt          = state_q;
        i2c_start          = 1'b0;
        i2c_wvalid         = 1'b0;
        is_i2c_master_done = 1'b0;
        capture            = 1'b0;
        load_attempt       = 1'b0;
        idx_inc            = 1'b0;
        retry_inc          = 1'b0;
        set_err            = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (trig_rise) begin
                    capture   = 1'b1;
                    state_nxt = ST_START;
                end
            end
            ST_START: begin
                i2c_start    = 1'b1;
                load_attempt = 1'b1;
                state_nxt    = ST_SEND;
            end
            ST_SEND: begin
                // An early stop from the master ends the attempt; valid is
                // withdrawn so no further byte can be accepted.
                if (i2c_txn_done) begin
                    state_nxt = i2c_nack ? ST_RETRY : ST_DONE;
                end else if (timeout_hit) begin
                    state_nxt = ST_RETRY;
                end else begin
                    i2c_wvalid = 1'b1;
                    if (i2c_wready) begin
                        if (byte_idx_q == IDX_LAST) begin
                            state_nxt = ST_WAIT_DONE;
                        end else begin
                            idx_inc = 1'b1;
                        end
                    end
                end
            end
            ST_WAIT_DONE: begin
                if (i2c_txn_done) begin
                    state_nxt = i2c_nack ? ST_RETRY : ST_DONE;
                end else if (timeout_hit) begin
                    state_nxt = ST_RETRY;
                end
            end
            ST_RETRY: begin
                if (retry_cnt < MAX_RETRY) begin
                    retry_inc = 1'b1;
                    state_nxt = ST_START;
                end else begin
                    set_err   = 1'b1;
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                is_i2c_master_done = 1'b1;
                state_nxt          = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_25MHZ or posedge reset) begin
        if (reset) begin
            trigger_d  <= 1'b0;
            frame_q    <= '0;
            byte_idx_q <= 3'd0;
            timer_q    <= 20'd0;
            retry_cnt  <= 2'd0;
            tx_error   <= 1'b0;
        end else begin
            trigger_d <= ball_send_trigger;
            if (capture) begin
                frame_q.y    <= ball_y;
                frame_q.vy   <= ball_vy;
                frame_q.g    <= gravity_counter;
                frame_q.slow <= (ball_speed >= SLOW_THRESH);
                retry_cnt    <= 2'd0;
            end
            if (retry_inc) begin
                retry_cnt <= retry_cnt + 2'd1;
            end
            if (set_err) begin
                tx_error <= 1'b1;
            end
            if (load_attempt) begin
                byte_idx_q <= 3'd0;
                timer_q    <= TIMEOUT_CYC - 20'd1;
            end else begin
                if (idx_inc) begin
                    byte_idx_q <= byte_idx_q + 3'd1;
                end
                if (in_window && (timer_q != 20'd0)) begin
                    timer_q <= timer_q - 20'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ball_tx_packetizer.sv
// Bench for ball_tx_packetizer: a responsive I2C master model, a frame model
// computed from the ball fields with plain arithmetic, and one compare
// process that checks the byte stream, pulse timing and status every cycle.
module tb_ball_tx_packetizer;

    localparam logic [19:0] T_CYC = 20'd120;
    localparam int TO   = 120;
    localparam int MAXR = 3;

    logic        clk_25MHZ;
    logic        reset;
    logic        ball_send_trigger;
    logic [9:0]  ball_y;
    logic [7:0]  ball_vy;
    logic [1:0]  gravity_counter;
    logic [19:0] ball_speed;
    logic        i2c_start;
    logic [6:0]  i2c_addr;
    logic [7:0]  i2c_wdata;
    logic        i2c_wvalid;
    logic        i2c_wlast;
    logic        i2c_wready;
    logic        i2c_txn_done;
    logic        i2c_nack;
    logic        is_i2c_master_done;
    logic        tx_busy;
    logic        tx_error;
    logic [1:0]  retry_cnt;

    ball_tx_packetizer #(
        .TIMEOUT_CYC (T_CYC)
    ) dut (
        .clk_25MHZ          (clk_25MHZ),
        .reset              (reset),
        .ball_send_trigger  (ball_send_trigger),
        .ball_y             (ball_y),
        .ball_vy            (ball_vy),
        .gravity_counter    (gravity_counter),
        .ball_speed         (ball_speed),
        .i2c_start          (i2c_start),
        .i2c_addr           (i2c_addr),
        .i2c_wdata          (i2c_wdata),
        .i2c_wvalid         (i2c_wvalid),
        .i2c_wlast          (i2c_wlast),
        .i2c_wready         (i2c_wready),
        .i2c_txn_done       (i2c_txn_done),
        .i2c_nack           (i2c_nack),
        .is_i2c_master_done (is_i2c_master_done),
        .tx_busy            (tx_busy),
        .tx_error           (tx_error),
        .retry_cnt          (retry_cnt)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // scoreboard state
    logic [7:0] exp_frame [6];
    int  n_starts, n_done, k;
    int  rise_cyc = -100;
    int  last_start, fail_cyc, ack_cyc;
    bit  cur_silent, exp_fail, exp_busy, exp_err_done, err_model;
    int  exp_retry;

    // master model controls
    int  m_nfail, m_fails_given, m_bytes, m_bp_byte, m_bp_left;
    int  m_delay = -1;
    bit  m_silent, m_early, m_always_ready;

    initial begin
        clk_25MHZ = 1'b0;
        forever #20 clk_25MHZ = ~clk_25MHZ;
    end

    initial forever begin
        @(posedge clk_25MHZ);
        cyc++;
    end

    initial begin
        #(40 * 60000);
        $display("FAIL global_timeout: simulation still running at cycle %0d, required finish", cyc);
        $fatal(1);
    end

    task automatic chk_eq(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Frame byte from the ball fields, by the peer's register meaning.
    function automatic logic [7:0] model_byte(input int idx, input int y, input int vy,
                                              input int g, input int spd);
        case (idx)
            0: return 8'h00;
            1: return 8'((y / 256) * 64);
            2: return 8'(y % 256);
            3: return 8'(vy);
            4: return 8'(g);
            5: return (spd >= 200000) ? 8'd1 : 8'd0;
            default: return 8'h00;
        endcase
    endfunction

    // I2C master: accepts bytes, answers each finished attempt with ACK or
    // NACK, optionally stalls, aborts early, or stays silent.
    initial begin
        bit s_start, s_hs, s_last;
        i2c_wready   = 1'b0;
        i2c_txn_done = 1'b0;
        i2c_nack     = 1'b0;
        forever begin
            @(negedge clk_25MHZ);
            s_start = i2c_start;
            s_hs    = i2c_wvalid && i2c_wready;
            s_last  = i2c_wlast;
            @(posedge clk_25MHZ);
            #1;
            i2c_txn_done = 1'b0;
            i2c_nack     = 1'b0;
            if (reset) begin
                m_delay    = -1;
                m_bytes    = 0;
                i2c_wready = 1'b0;
            end else begin
                if (s_start) m_bytes = 0;
                if (s_hs) begin
                    m_bytes++;
                    if (s_last && !m_silent) m_delay = $urandom_range(0, 3);
                end
                if (m_delay == 0) begin
                    i2c_txn_done = 1'b1;
                    i2c_nack     = (m_fails_given < m_nfail);
                    m_fails_given++;
                    m_delay      = -1;
                end else if (m_delay > 0) begin
                    m_delay--;
                end
                if (m_early && m_bytes == 2 && !i2c_txn_done) begin
                    i2c_txn_done = 1'b1;
                    i2c_nack     = (m_fails_given < m_nfail);
                    m_fails_given++;
                    m_early      = 1'b0;
                end
                if (m_bp_left > 0 && m_bytes == m_bp_byte) begin
                    i2c_wready = 1'b0;
                    m_bp_left--;
                end else begin
                    i2c_wready = m_always_ready ? 1'b1 : ($urandom_range(0, 3) != 0);
                end
            end
        end
    end

    // Compare process
    initial forever begin
        @(negedge clk_25MHZ);
        if (!reset) begin
            if (cyc == rise_cyc + 1) exp_busy = 1'b1;
            chk_eq("tx_busy", tx_busy, exp_busy);
            if (i2c_start) begin
                n_starts++;
                if (n_starts == 1)   chk_eq("start_latency", cyc - rise_cyc, 1);
                else if (cur_silent) chk_eq("timeout_restart", cyc - last_start, TO + 2);
                else                 chk_eq("nack_restart", cyc - fail_cyc, 2);
                chk_eq("i2c_addr", i2c_addr, 7'h17);
                last_start = cyc;
                k = 0;
            end
            if (i2c_wvalid) begin
                if (k > 5) begin
                    chk_eq("extra_byte_index", k, 5);
                end else begin
                    chk_eq($sformatf("wdata[%0d]", k), i2c_wdata, exp_frame[k]);
                    chk_eq($sformatf("wlast[%0d]", k), i2c_wlast, (k == 5));
                    if (i2c_wready) k++;
                end
            end else begin
                chk_eq("wlast_without_valid", i2c_wlast, 0);
            end
            if (i2c_txn_done) begin
                if (i2c_nack) fail_cyc = cyc;
                else          ack_cyc  = cyc;
            end
            if (is_i2c_master_done) begin
                n_done++;
                if (!exp_fail)       chk_eq("done_after_ack", cyc - ack_cyc, 1);
                else if (cur_silent) chk_eq("done_after_timeout", cyc - last_start, TO + 2);
                else                 chk_eq("done_after_last_nack", cyc - fail_cyc, 2);
                chk_eq("retry_cnt_at_done", retry_cnt, exp_retry);
                chk_eq("tx_error_at_done", tx_error, exp_err_done);
                exp_busy = 1'b0;
            end
        end
    end

    // trig_mode: 0 hold until done, 1 drop mid-frame, 2 drop then re-rise while busy
    task automatic do_send(input logic [9:0] y, input logic [7:0] vy, input logic [1:0] g,
                           input logic [19:0] spd, input int nfail, input bit silent,
                           input bit early, input int bp_byte, input int bp_len,
                           input bit ready1, input int trig_mode);
        int exp_att;
        int waited;
        for (int i = 0; i < 6; i++) exp_frame[i] = model_byte(i, int'(y), int'(vy), int'(g), int'(spd));
        exp_fail      = silent || (nfail > MAXR);
        exp_att       = exp_fail ? MAXR + 1 : nfail + 1;
        exp_retry     = exp_att - 1;
        exp_err_done  = err_model || exp_fail;
        cur_silent    = silent;
        m_silent      = silent;
        m_nfail       = nfail;
        m_fails_given = 0;
        m_early       = early;
        m_bp_byte     = bp_byte;
        m_bp_left     = bp_len;
        m_always_ready = ready1;
        n_starts      = 0;
        n_done        = 0;
        k             = 0;
        @(posedge clk_25MHZ);
        #1;
        ball_y            = y;
        ball_vy           = vy;
        gravity_counter   = g;
        ball_speed        = spd;
        ball_send_trigger = 1'b1;
        rise_cyc          = cyc;
        waited            = 0;
        while (n_done == 0 && waited < 3000) begin
            @(posedge clk_25MHZ);
            #1;
            waited++;
            ball_y          = 10'($urandom);
            ball_vy         = 8'($urandom);
            gravity_counter = 2'($urandom);
            ball_speed      = 20'($urandom);
            if (trig_mode != 0 && waited == 2) ball_send_trigger = 1'b0;
            if (trig_mode == 2 && waited == 3) ball_send_trigger = 1'b1;
        end
        chk_eq("send_completes", (n_done > 0), 1);
        ball_send_trigger = 1'b0;
        repeat (4) @(posedge clk_25MHZ);
        #1;
        chk_eq("start_count", n_starts, exp_att);
        chk_eq("done_count", n_done, 1);
        err_model = err_model || exp_fail;
        rise_cyc  = -100;
    endtask

    initial begin
        logic [7:0] pin [6];
        int nf;
        reset = 1'b0;
        ball_send_trigger = 1'b0;
        ball_y = '0; ball_vy = '0; gravity_counter = '0; ball_speed = '0;
        err_model = 1'b0;
        exp_busy  = 1'b0;
        m_nfail = 0; m_fails_given = 0; m_bytes = 0; m_bp_byte = 0; m_bp_left = 0;
        m_silent = 1'b0; m_early = 1'b0; m_always_ready = 1'b1;
        n_starts = 0; n_done = 0; k = 0; last_start = 0; fail_cyc = 0; ack_cyc = 0;

        // model pins
        pin = '{8'h00, 8'h80, 8'hD5, 8'hFD, 8'h02, 8'h01};
        for (int i = 0; i < 6; i++)
            chk_eq($sformatf("model_pin%0d", i), model_byte(i, 'h2D5, 'hFD, 2, 270000), pin[i]);
        chk_eq("model_slow_below", model_byte(5, 0, 0, 0, 199999), 8'h00);
        chk_eq("model_slow_at", model_byte(5, 0, 0, 0, 200000), 8'h01);

        #5 reset = 1'b1;
        #5;
        chk_eq("rst_start", i2c_start, 0);
        chk_eq("rst_addr", i2c_addr, 7'h17);
        chk_eq("rst_wdata", i2c_wdata, 0);
        chk_eq("rst_wvalid", i2c_wvalid, 0);
        chk_eq("rst_wlast", i2c_wlast, 0);
        chk_eq("rst_done", is_i2c_master_done, 0);
        chk_eq("rst_busy", tx_busy, 0);
        chk_eq("rst_error", tx_error, 0);
        chk_eq("rst_retry", retry_cnt, 0);
        repeat (3) @(posedge clk_25MHZ);
        #1 reset = 1'b0;
        repeat (2) @(posedge clk_25MHZ);

        // basic, backpressure on byte 3, NACK twice, early NACK
        do_send(10'h2D5, 8'hFD, 2'd2, 20'd270000, 0, 0, 0, 0, 0, 1, 0);
        do_send(10'h2D5, 8'hFD, 2'd2, 20'd270000, 0, 0, 0, 3, 4, 1, 0);
        do_send(10'h13A, 8'h05, 2'd1, 20'd199999, 2, 0, 0, 0, 0, 1, 0);
        do_send(10'h3FF, 8'h80, 2'd3, 20'd200000, 1, 0, 1, 0, 0, 1, 1);

        for (int n = 0; n < 10; n++) begin
            nf = $urandom_range(0, 2);
            do_send(10'($urandom), 8'($urandom), 2'($urandom),
                    (n % 3 == 0) ? 20'd199999 : (n % 3 == 1) ? 20'd200000 : 20'($urandom),
                    nf, 0, (nf > 0) && ($urandom_range(0, 1) == 1),
                    $urandom_range(0, 5), $urandom_range(0, 5), 0, n % 3);
        end

        // trigger drop + re-rise while busy
        do_send(10'h0AA, 8'h7F, 2'd0, 20'd5, 0, 0, 0, 2, 5, 1, 2);
        // persistent NACK, then sticky error on a good send
        do_send(10'h155, 8'hC3, 2'd2, 20'd300000, 4, 0, 0, 0, 0, 0, 0);
        do_send(10'h201, 8'h01, 2'd1, 20'd1, 0, 0, 0, 0, 0, 1, 1);
        // silent master: watchdog on every attempt
        do_send(10'h099, 8'hE0, 2'd3, 20'd250000, 0, 1, 0, 0, 0, 1, 0);

        // reset while in SEND
        for (int i = 0; i < 6; i++) exp_frame[i] = model_byte(i, 'h111, 'h22, 1, 0);
        exp_fail = 0; cur_silent = 0; m_silent = 0; m_nfail = 0; m_fails_given = 0;
        m_early = 0; m_bp_byte = 4; m_bp_left = 20; m_always_ready = 1;
        n_starts = 0; n_done = 0; k = 0;
        @(posedge clk_25MHZ);
        #1;
        ball_y = 10'h111; ball_vy = 8'h22; gravity_counter = 2'd1; ball_speed = 20'd0;
        ball_send_trigger = 1'b1;
        rise_cyc = cyc;
        repeat (4) @(posedge clk_25MHZ);
        #1;
        chk_eq("pre_reset_wvalid", i2c_wvalid, 1);
        chk_eq("pre_reset_error", tx_error, 1);
        reset = 1'b1;
        #1;
        chk_eq("midrst_start", i2c_start, 0);
        chk_eq("midrst_addr", i2c_addr, 7'h17);
        chk_eq("midrst_wdata", i2c_wdata, 0);
        chk_eq("midrst_wvalid", i2c_wvalid, 0);
        chk_eq("midrst_wlast", i2c_wlast, 0);
        chk_eq("midrst_done", is_i2c_master_done, 0);
        chk_eq("midrst_busy", tx_busy, 0);
        chk_eq("midrst_error", tx_error, 0);
        chk_eq("midrst_retry", retry_cnt, 0);
        ball_send_trigger = 1'b0;
        m_bp_left = 0;
        rise_cyc  = -100;
        exp_busy  = 1'b0;
        err_model = 1'b0;
        repeat (2) @(posedge clk_25MHZ);
        #1 reset = 1'b0;
        repeat (2) @(posedge clk_25MHZ);

        // recovery after reset
        do_send(10'h2D5, 8'hFD, 2'd2, 20'd270000, 1, 0, 0, 1, 2, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
